bp_stall_profile_ctrl: RTL



---
 rtl/bp_profiler_pkg.sv | 32 +++
 rtl/bp_stall_profile_ctrl_if.sv | 42 ++++
 rtl/bp_sat_counter.sv | 40 ++++
 rtl/bp_stall_profile_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bp_profiler_pkg.sv
// Shared types and dump-index helpers for the stall-reason profiler.
// Imported by the profiler control block and the testbench.
package bp_profiler_pkg;

  typedef enum logic [1:0] {
    e_prof_start = 2'd0,
    e_prof_stop  = 2'd1,
    e_prof_clear = 2'd2,
    e_prof_dump  = 2'd3
  } bp_prof_cmd_e;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_run   = 2'd1,
    e_dump  = 2'd2,
    e_clear = 2'd3
  } bp_prof_state_e;

  // The cycle and instret words follow the reason counters in the dump stream.
  localparam int prof_cycle_ofs_c   = 0;
  localparam int prof_instret_ofs_c = 1;
  localparam int prof_num_extra_c   = 2;

  function automatic int dump_cycle_idx(input int num_reasons);
    return num_reasons + prof_cycle_ofs_c;
  endfunction

  function automatic int dump_instret_idx(input int num_reasons);
    return num_reasons + prof_instret_ofs_c;
  endfunction

endpackage

// File: rtl/bp_stall_profile_ctrl_if.sv
// Host command port and dump stream of the stall profiler.
// The master side is the host / cosim shell, the slave side is the profiler.
interface bp_stall_profile_ctrl_if #(
  parameter int cnt_width_p    = 32,
  parameter int reason_width_p = 5
);

  logic                      cmd_v_i;
  logic [1:0]                cmd_i;
  logic                      cmd_ready_o;
  logic                      running_o;
  logic                      data_v_o;
  logic [cnt_width_p-1:0]    data_o;
  logic [reason_width_p:0]   data_idx_o;
  logic                      data_last_o;
  logic                      data_yumi_i;

  modport master (
    output cmd_v_i,
    output cmd_i,
    input  cmd_ready_o,
    input  running_o,
    input  data_v_o,
    input  data_o,
    input  data_idx_o,
    input  data_last_o,
    output data_yumi_i
  );

  modport slave (
    input  cmd_v_i,
    input  cmd_i,
    output cmd_ready_o,
    output running_o,
    output data_v_o,
    output data_o,
    output data_idx_o,
    output data_last_o,
    input  data_yumi_i
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clear_i,
  input  logic                   up_i,
  output logic [cnt_width_p-1:0] count_o
);

  localparam logic [cnt_width_p-1:0] max_c = '1;

  logic [cnt_width_p-1:0] count_q;
  logic [cnt_width_p-1:0] count_d;

  // Next count: clear wins over increment, increment stops at max.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && (count_q != max_c)) begin
      count_d = count_q + cnt_width_p'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_stall_profile_ctrl.sv
// Run-control and readout sequencer for the per-core stall-reason counter bank.
// Counts stall reasons, cycles and retired instructions; dumps them over a valid/yumi stream.
module bp_stall_profile_ctrl
  import bp_profiler_pkg::*;
#(
  parameter int num_reasons_p  = 24,
  parameter int cnt_width_p    = 32,
  parameter int reason_width_p = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      stall_v_i,
  input  logic [reason_width_p-1:0] stall_reason_i,
  input  logic                      instret_i,
  bp_stall_profile_ctrl_if.slave    prof_if
);

  localparam int idx_width_c = reason_width_p + 1;
  localparam int num_words_c = num_reasons_p + prof_num_extra_c;
  localparam int mux_size_c  = 1 << idx_width_c;
  localparam int cycle_idx_c = dump_cycle_idx(num_reasons_p);
  localparam int instret_idx_c = dump_instret_idx(num_reasons_p);
  localparam logic [idx_width_c-1:0] last_idx_c = idx_width_c'(instret_idx_c);

  bp_prof_state_e           state_q;
  bp_prof_state_e           state_d;
  logic                     resume_q;
  logic                     resume_d;
  logic [idx_width_c-1:0]   idx_q;
  logic [idx_width_c-1:0]   idx_d;

  bp_prof_cmd_e             cmd_s;
  logic                     cmd_ready_s;
  logic                     cmd_fire_s;
  logic                     run_s;
  logic                     clear_s;
  logic                     dump_v_s;
  logic                     reason_ok_s;

  logic [cnt_width_p-1:0]   cnt_s [mux_size_c];

  assign cmd_s       = bp_prof_cmd_e'(prof_if.cmd_i);
  assign cmd_ready_s = (state_q == e_idle) || (state_q == e_run);
  assign cmd_fire_s  = prof_if.cmd_v_i & cmd_ready_s;
  assign run_s       = (state_q == e_run);
  assign clear_s     = (state_q == e_clear);
  assign dump_v_s    = (state_q == e_dump);
  // A retiring instruction takes precedence over any reported stall reason.
  assign reason_ok_s = run_s & stall_v_i & ~instret_i;

  // Next-state, resume flag and dump index.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    idx_d    = idx_q;
    case (state_q)
      e_idle: begin
        if (cmd_fire_s) begin
          case (cmd_s)
            e_prof_start: state_d = e_run;
            e_prof_clear: state_d = e_clear;
            e_prof_dump: begin
              state_d  = e_dump;
              resume_d = 1'b0;
              idx_d    = '0;
            end
            default: state_d = e_idle;
          endcase
        end else begin
          state_d = e_idle;
        end
      end
      e_run: begin
        if (cmd_fire_s) begin
          case (cmd_s)
            e_prof_stop:  state_d = e_idle;
            e_prof_clear: state_d = e_clear;
            e_prof_dump: begin
              state_d  = e_dump;
              resume_d = 1'b1;
              idx_d    = '0;
            end
            default: state_d = e_run;
          endcase
        end else begin
          state_d = e_run;
        end
      end
      e_dump: begin
        if (prof_if.data_yumi_i) begin
          if (idx_q == last_idx_c) begin
            idx_d   = '0;
            state_d = resume_q ? e_run : e_idle;
          end else begin
            idx_d = idx_q + idx_width_c'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      e_clear: begin
        state_d = e_idle;
      end
      default: begin
        state_d  = e_idle;
        resume_d = 1'b0;
        idx_d    = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      resume_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      idx_q    <= idx_d;
    end
  end

  // Codes at or above num_reasons_p match no counter and are dropped.
  for (genvar i = 0; i < num_reasons_p; i++) begin : g_reason
    bp_sat_counter #(.cnt_width_p(cnt_width_p)) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (clear_s),
      .up_i      (reason_ok_s & (stall_reason_i == reason_width_p'(i))),
      .count_o   (cnt_s[i])
    );
  end

  bp_sat_counter #(.cnt_width_p(cnt_width_p)) u_cycle_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_s),
    .up_i      (run_s),
    .count_o   (cnt_s[cycle_idx_c])
  );

  bp_sat_counter #(.cnt_width_p(cnt_width_p)) u_instret_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_s),
    .up_i      (run_s & instret_i),
    .count_o   (cnt_s[instret_idx_c])
  );

  // Pad the readout mux to a power of two so the index needs no range guard.
  for (genvar j = num_words_c; j < mux_size_c; j++) begin : g_pad
    assign cnt_s[j] = '0;
  end

  assign prof_if.cmd_ready_o = cmd_ready_s;
  assign prof_if.running_o   = run_s;
  assign prof_if.data_v_o    = dump_v_s;
  assign prof_if.data_o      = cnt_s[idx_q];
  assign prof_if.data_idx_o  = idx_q;
  assign prof_if.data_last_o = dump_v_s & (idx_q == last_idx_c);

endmodule
